// File: rtl/cla16_adder.sv
// 16-bit adder from GROUP-bit carry-lookahead blocks with ripple carry between groups.
// Optional subtract mode (input port sub) is enabled by defining CLA16_SUB_EN.
module cla16_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             c_in,
`ifdef CLA16_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ready
);

  localparam int NGROUPS = WIDTH / GROUP;

  logic [WIDTH-1:0] b_eff;
  logic             c0;

`ifdef CLA16_SUB_EN
  // Subtraction is A + ~B + 1, so the +1 replaces the external carry-in.
  assign b_eff = sub ? ~B : B;
  assign c0    = sub ? 1'b1 : c_in;
`else
  assign b_eff = B;
  assign c0    = c_in;
`endif

  logic [WIDTH-1:0]   g, p, carry, sum;
  logic [NGROUPS:0]   group_c;

  assign g          = A & b_eff;
  assign p          = A ^ b_eff;
  assign group_c[0] = c0;

  // Carry into bit k of a group in flattened lookahead form:
  // c_k = OR_j (g_j & p_{j+1..k-1}) | (c_grp & p_{0..k-1}).
  function automatic logic lookahead_carry(input logic [GROUP-1:0] gg,
                                           input logic [GROUP-1:0] pp,
                                           input logic             cin,
                                           input int               k);
    logic c, prod;
    c = 1'b0;
    for (int j = 0; j < k; j++) begin
      prod = gg[j];
      for (int m = j + 1; m < k; m++) prod = prod & pp[m];
      c = c | prod;
    end
    prod = cin;
    for (int m = 0; m < k; m++) prod = prod & pp[m];
    return c | prod;
  endfunction

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
    for (genvar k = 0; k < GROUP; k++) begin : g_bit
      assign carry[gi*GROUP+k] = lookahead_carry(g[gi*GROUP +: GROUP], p[gi*GROUP +: GROUP],
                                                 group_c[gi], k);
    end
    assign group_c[gi+1] = lookahead_carry(g[gi*GROUP +: GROUP], p[gi*GROUP +: GROUP],
                                           group_c[gi], GROUP);
  end

  assign sum    = p ^ carry;
  assign Output = en ? sum : '0;
  assign c_out  = en & group_c[NGROUPS];

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) ready <= 1'b0;
    else     ready <= en;
  end

endmodule

// File: tb/tb_cla16_adder.sv
// Self-checking bench for cla16_adder: directed corner cases plus random vectors
// against an arithmetic reference model; covers ready timing and async reset.
module tb_cla16_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        c_in;
  logic [15:0] A, B;
  logic [15:0] Output;
  logic        c_out;
  logic        ready;
`ifdef CLA16_SUB_EN
  logic        sub = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  cla16_adder dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .c_in   (c_in),
`ifdef CLA16_SUB_EN
    .sub    (sub),
`endif
    .A      (A),
    .B      (B),
    .Output (Output),
    .c_out  (c_out),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        c;
  } vec_t;

  // Reference: plain integer arithmetic on a 17-bit result.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic do_sub, input logic e);
    logic [16:0] r;
    if (!e) return 17'd0;
    if (do_sub) begin
      r[15:0] = a - b;
      r[16]   = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    end
    return r;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci);
    @(negedge clk);
    A = a; B = b; c_in = ci;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; c_in = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    #12;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL post_reset_ready: got %b want 0", ready); end
    checks++;
    if (Output !== 16'h0000 || c_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_out: got %h/%b want 0000/0", Output, c_out);
    end
  endtask

  task automatic test_directed();
    vec_t v[5];
    v[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    v[2] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    v[3] = '{16'h0000, 16'hFFFD, 1'b0, 16'hFFFD, 1'b0};
    v[4] = '{16'h0007, 16'hFFFD, 1'b0, 16'h0004, 1'b1};
    @(negedge clk);
    en = 1'b1; A = v[0].a; B = v[0].b; c_in = v[0].ci;
    #1;
    checks++;
    if (Output !== v[0].s || c_out !== v[0].c) begin
      errors++; $display("FAIL same_cycle_sum: got %h/%b want %h/%b", Output, c_out, v[0].s, v[0].c);
    end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b want 0", ready); end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b want 1", ready); end
    for (int i = 1; i < 5; i++) begin
      drive(v[i].a, v[i].b, v[i].ci);
      checks++;
      if (Output !== v[i].s || c_out !== v[i].c) begin
        errors++;
        $display("FAIL directed_%0d: A=%h B=%h ci=%b got %h/%b want %h/%b",
                 i, v[i].a, v[i].b, v[i].ci, Output, c_out, v[i].s, v[i].c);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [15:0] a, b;
    logic        ci;
    logic [16:0] exp;
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      drive(a, b, ci);
      exp = model(a, b, ci, 1'b0, 1'b1);
      checks++;
      if ({c_out, Output} !== exp) begin
        errors++;
        $display("FAIL random_add: A=%h B=%h ci=%b got %b/%h want %b/%h",
                 a, b, ci, c_out, Output, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_enable_gating();
    @(negedge clk); en = 1'b0; A = 16'hFFFF; B = 16'hFFFF; c_in = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_fall_early: got %b want 1", ready); end
    for (int i = 0; i < 6; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom));
      checks++;
      if (Output !== 16'h0000 || c_out !== 1'b0) begin
        errors++; $display("FAIL gated_out: got %h/%b want 0000/0", Output, c_out);
      end
    end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL ready_fall: got %b want 0", ready); end
  endtask

  task automatic test_reset_midop();
    logic [16:0] exp;
    @(negedge clk); en = 1'b1; A = 16'h00FF; B = 16'h0F01; c_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midop_ready_pre: got %b want 1", ready); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL async_reset: got %b want 0", ready); end
    exp = model(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({c_out, Output} !== exp) begin
      errors++; $display("FAIL reset_comb: got %b/%h want %b/%h", c_out, Output, exp[16], exp[15:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_release: got %b want 1", ready); end
  endtask

`ifdef CLA16_SUB_EN
  task automatic test_sub(input int n);
    logic [15:0] a, b;
    logic        ci;
    logic [16:0] exp;
    en = 1'b1; sub = 1'b1;
    drive(16'h0005, 16'h0003, 1'b0);
    checks++;
    if (Output !== 16'h0002 || c_out !== 1'b1) begin
      errors++; $display("FAIL sub_5_3: got %h/%b want 0002/1", Output, c_out);
    end
    drive(16'h0003, 16'h0005, 1'b0);
    checks++;
    if (Output !== 16'hFFFE || c_out !== 1'b0) begin
      errors++; $display("FAIL sub_3_5: got %h/%b want FFFE/0", Output, c_out);
    end
    for (int i = 0; i < n; i++) begin
      a  = 16'($urandom);
      b  = (i % 8 == 0) ? a : 16'($urandom);
      ci = 1'($urandom);
      drive(a, b, ci);
      exp = model(a, b, ci, 1'b1, 1'b1);
      checks++;
      if ({c_out, Output} !== exp) begin
        errors++;
        $display("FAIL random_sub: A=%h B=%h ci=%b got %b/%h want %b/%h",
                 a, b, ci, c_out, Output, exp[16], exp[15:0]);
      end
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random(200);
    test_enable_gating();
    test_reset_midop();
`ifdef CLA16_SUB_EN
    test_sub(100);
`endif
    test_random(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
